// File: rtl/uart_rx_frontend.sv
// UART receiver front end: 2-FF synchroniser, mid-bit sampling FSM and a one-byte
// holding register with valid/ack handshake. Optional parity via `UART_RX_PARITY_EN`.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       uart_rxd,
    output logic [7:0] data_out,
    output logic       data_valid_out,
    input  logic       data_ack_in,
    output logic       frame_err_out,
    output logic       parity_err_out,
    output logic       overrun_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // The counter expires on zero, so loading (period - 1) yields exactly one period.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic       PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`else
    logic unused_parity_s;
    assign unused_parity_s = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`endif

    logic [1:0]    sync_q, sync_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_mis_q, par_mis_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          overrun_q, overrun_d;
    logic          rx_s, expired_s, commit_s, ack_s;

    assign rx_s      = sync_q[1];
    assign expired_s = (cnt_q == CNT_ZERO);
    assign ack_s     = valid_q & data_ack_in;
    assign sync_d    = {sync_q[0], uart_rxd};

    // Frame FSM: start detection, bit pacing, sampling and stop-bit outcome.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        commit_s     = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (expired_s) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q - CNT_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d     = HALF_LOAD;
                    par_mis_d = 1'b0;
                    state_d   = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (expired_s) begin
                    if (!rx_s) begin
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = 3'd0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (expired_s) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expired_s) begin
                    par_mis_d = (rx_s != ((^shift_q) ^ PAR_ODD));
                    cnt_d     = BIT_LOAD;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (expired_s) begin
                    if (rx_s) begin
                        if (par_mis_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            commit_s = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: commit wins over ack for data, and a same-cycle ack clears overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (commit_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (ack_s) begin
                overrun_d = 1'b0;
            end else if (valid_q) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (ack_s) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers; synchroniser resets to the idle line level.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_mis_q    <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign frame_err_out  = frame_err_q;
    assign parity_err_out = parity_err_q;
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at 16 clocks per bit; parity scenario
// runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frontend;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int VALID_CYC = 2 + 8 + 10 * BIT + 1;
`else
    localparam int VALID_CYC = 2 + 8 + 9 * BIT + 1;
`endif

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       uart_rxd;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic       data_ack_in;
    logic       frame_err_out;
    logic       parity_err_out;
    logic       overrun_out;

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_frontend #(.CLKS_PER_BIT(BIT), .PARITY_ODD(0)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .uart_rxd       (uart_rxd),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ack_in    (data_ack_in),
        .frame_err_out  (frame_err_out),
        .parity_err_out (parity_err_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (frame_err_out)  fe_cnt <= fe_cnt + 1;
        if (parity_err_out) pe_cnt <= pe_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        tick(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
        if (stop_b && par_ok) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? (^d) : ~(^d));
`endif
        drive_bit(stop_b);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_in);
            if (data_valid_out) ok = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        @(posedge clk_in);
        #1 data_ack_in = 1'b1;
        @(posedge clk_in);
        #1 data_ack_in = 1'b0;
        @(negedge clk_in);
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 8'hxx;
    endfunction

    task automatic test_reset();
        @(negedge clk_in);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid_out); end
        checks++; if (frame_err_out !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err_out); end
        checks++; if (parity_err_out !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err_out); end
        checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun_out); end
    endtask

    task automatic test_clean_frame();
        int cyc = 0;
        bit seen = 1'b0;
        int fe0 = fe_cnt;
        int pe0 = pe_cnt;
        logic [7:0] exp_b;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 300 && !seen; i++) begin
                    @(posedge clk_in);
                    cyc++;
                    @(negedge clk_in);
                    if (data_valid_out) seen = 1'b1;
                end
            end
        join
        checks++; if (!seen || cyc != VALID_CYC) begin errors++; $display("FAIL clean_latency got %0d (seen %0b) want %0d", cyc, seen, VALID_CYC); end
        exp_b = pop_exp();
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL clean_data got %h want %h", data_out, exp_b); end
        checks++; if (fe_cnt != fe0 || pe_cnt != pe0) begin errors++; $display("FAIL clean_no_err got fe %0d pe %0d want 0 0", fe_cnt - fe0, pe_cnt - pe0); end
        pulse_ack();
        checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL clean_ack got %b want 0", data_valid_out); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp_b;
        fork
            begin
                send_frame(8'h00, 1'b1, 1'b1);
                send_frame(8'hFF, 1'b1, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_valid(400, ok);
                    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout byte %0d got no valid want valid", k); end
                    exp_b = pop_exp();
                    checks++; if (data_out !== exp_b) begin errors++; $display("FAIL b2b_data byte %0d got %h want %h", k, data_out, exp_b); end
                    pulse_ack();
                    checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_ack byte %0d got %b want 0", k, data_valid_out); end
                    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL b2b_ovr byte %0d got %b want 0", k, overrun_out); end
                end
            end
        join
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        @(negedge clk_in);
        exp_b = pop_exp();
        exp_b = pop_exp();
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL ovr_data got %h want %h", data_out, exp_b); end
        checks++; if (data_valid_out !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", data_valid_out); end
        checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun_out); end
        pulse_ack();
        checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid got %b want 0", data_valid_out); end
        checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_ack_flag got %b want 0", overrun_out); end
    endtask

    task automatic test_framing();
        int fe0 = fe_cnt;
        bit ok;
        logic [7:0] exp_b;
        send_frame(8'h3C, 1'b0, 1'b1);
        tick(40);
        uart_rxd = 1'b1;
        tick(20);
        @(negedge clk_in);
        checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", fe_cnt - fe0); end
        checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL frame_valid got %b want 0", data_valid_out); end
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_valid(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_recover_timeout got no valid want valid"); end
        exp_b = pop_exp();
        checks++; if (data_out !== exp_b) begin errors++; $display("FAIL frame_recover_data got %h want %h", data_out, exp_b); end
        pulse_ack();
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt;
        bit ok;
        logic [7:0] exp_b;
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(40);
        @(negedge clk_in);
        checks++; if (data_valid_out !== 1'b0 || fe_cnt != fe0) begin errors++; $display("FAIL glitch_quiet got valid %b fe %0d want 0 0", data_valid_out, fe_cnt - fe0); end
        send_frame(8'h96, 1'b1, 1'b1);
        wait_valid(300, ok);
        exp_b = pop_exp();
        checks++; if (!ok || data_out !== exp_b) begin errors++; $display("FAIL glitch_next got %h (valid %0b) want %h", data_out, ok, exp_b); end
        pulse_ack();
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [7:0] exp_b;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        exp_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        uart_rxd = 1'b1;
        tick(BIT / 2);
        reset_in = 1'b0;
        @(negedge clk_in);
        checks++; if (data_out !== 8'h00 || data_valid_out !== 1'b0 || overrun_out !== 1'b0 || frame_err_out !== 1'b0 || parity_err_out !== 1'b0)
            begin errors++; $display("FAIL midreset_outputs got %h %b %b %b %b want 00 0 0 0 0", data_out, data_valid_out, overrun_out, frame_err_out, parity_err_out); end
        tick(3);
        reset_in = 1'b1;
        tick(40);
        send_frame(8'hC3, 1'b1, 1'b1);
        wait_valid(300, ok);
        exp_b = pop_exp();
        checks++; if (!ok || data_out !== exp_b) begin errors++; $display("FAIL midreset_next got %h (valid %0b) want %h", data_out, ok, exp_b); end
        checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL midreset_ovr got %b want 0", overrun_out); end
        pulse_ack();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0 = pe_cnt;
        bit ok;
        logic [7:0] exp_b;
        send_frame(8'h07, 1'b1, 1'b0);
        tick(10);
        @(negedge clk_in);
        checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL parity_pulse got %0d want 1", pe_cnt - pe0); end
        checks++; if (data_valid_out !== 1'b0) begin errors++; $display("FAIL parity_drop got %b want 0", data_valid_out); end
        send_frame(8'h07, 1'b1, 1'b1);
        wait_valid(300, ok);
        exp_b = pop_exp();
        checks++; if (!ok || data_out !== exp_b) begin errors++; $display("FAIL parity_good got %h (valid %0b) want %h", data_out, ok, exp_b); end
        pulse_ack();
    endtask
`endif

    initial begin
        reset_in    = 1'b0;
        uart_rxd    = 1'b1;
        data_ack_in = 1'b0;
        tick(3);
        test_reset();
        tick(1);
        reset_in = 1'b1;
        tick(5);
        test_clean_frame();
        tick(20);
        test_back_to_back();
        tick(20);
        test_overrun();
        tick(20);
        test_framing();
        tick(20);
        test_glitch();
        tick(20);
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        tick(20);
        test_parity();
`endif
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
